// File: rtl/sort_frame_serializer_if.sv
// Frame-in / beat-out handshake bundle for the sorted-frame serializer.
// slave is the serializer's view, master is the upstream/sink side.
interface sort_frame_serializer_if #(
  parameter int WIDTH = 8,
  parameter int N     = 6,
  parameter int IDXW  = $clog2(N)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IDXW-1:0]      out_idx;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_idx, out_last
  );
endinterface

// File: rtl/sort_frame_serializer.sv
// Captures a sorted N-element frame and streams it one element per beat,
// flagging out-of-order beats and counting completed frames.
module sort_frame_serializer #(
  parameter int WIDTH = 8,
  parameter int N     = 6,
  parameter int IDXW  = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst_n,
  sort_frame_serializer_if.slave bus,
  output logic       order_err,
  output logic [7:0] frame_cnt
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [N-1:0][WIDTH-1:0]  r_buf;
  logic [IDXW-1:0]          r_idx;
  logic [WIDTH-1:0]         r_prev;
  logic                     r_order_err;
  logic [7:0]               r_frame_cnt;

  logic w_out_valid;
  logic w_last;
  logic w_acc;
  logic w_last_acc;
  logic w_in_ready;
  logic w_cap;

  assign w_last     = w_out_valid & (r_idx == IDXW'(N-1));
  assign w_acc      = w_out_valid & bus.out_ready;
  assign w_last_acc = w_acc & w_last;
  assign w_cap      = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_cap) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_acc && !bus.in_valid) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_valid = 1'b0;
    w_in_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
      end
      S_STREAM: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready & (r_idx == IDXW'(N-1));
      end
      default: begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
      end
    endcase
  end

  // Capture wins over index advance so back-to-back frames restart at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_cap) begin
      r_buf <= bus.in_data;
      r_idx <= '0;
    end else if (w_acc) begin
      r_idx <= w_last ? '0 : r_idx + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_order_err <= 1'b0;
      r_frame_cnt <= '0;
    end else if (w_acc) begin
      r_prev <= r_buf[r_idx];
      if (r_idx != '0 && r_buf[r_idx] < r_prev)
        r_order_err <= 1'b1;
      if (w_last)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_buf[r_idx];
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = w_last;
  assign order_err     = r_order_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_sort_frame_serializer.sv
// Directed bench for sort_frame_serializer: streaming, stalls, back-to-back
// frames, order error, mid-frame reset and frame counter wrap.
module tb_sort_frame_serializer;
  localparam int W = 8;
  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       order_err;
  logic [7:0] frame_cnt;
  int         errs = 0;
  int         total = 0;

  sort_frame_serializer_if #(.WIDTH(W), .N(N)) bus ();

  sort_frame_serializer #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .order_err (order_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] FA =
    {8'd200, 8'd40, 8'd12, 8'd9, 8'd7, 8'd3};
  localparam logic [47:0] FB =
    {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
  localparam logic [47:0] FC =
    {8'd255, 8'd254, 8'd100, 8'd2, 8'd1, 8'd0};
  localparam logic [47:0] FU =
    {8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd5};
  localparam logic [47:0] F16 =
    {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

  task automatic check(input string tag,
                       input int got, input int exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int el(input logic [47:0] f, input int k);
    return int'(f[k*8 +: 8]);
  endfunction

  // Capture one frame and drain it at full rate.
  task automatic send(input logic [47:0] f, input bit chk);
    bus.in_valid  = 1'b1;
    bus.in_data   = f;
    bus.out_ready = 1'b1;
    if (chk) check("cap_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (chk) begin
        check("s_valid", int'(bus.out_valid), 1);
        check("s_data", int'(bus.out_data), el(f, k));
        check("s_idx", int'(bus.out_idx), k);
        check("s_last", int'(bus.out_last), int'(k == N-1));
      end
      tick();
    end
  endtask

  initial begin
    int k;
    int cyc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_idx", int'(bus.out_idx), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_err", int'(order_err), 0);
    check("rst_cnt", int'(frame_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_inrdy", int'(bus.in_ready), 1);

    // Full-rate single frame
    send(FA, 1'b1);
    check("a_idle", int'(bus.out_valid), 0);
    check("a_cnt", int'(frame_cnt), 1);
    check("a_err", int'(order_err), 0);
    check("a_inrdy", int'(bus.in_ready), 1);

    // Alternating stalls; data changes mid-stream must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = FA;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = FB;
    k = 0;
    cyc = 0;
    while (k < N && cyc < 40) begin
      bus.out_ready = cyc[0];
      check("st_valid", int'(bus.out_valid), 1);
      check("st_data", int'(bus.out_data), el(FA, k));
      check("st_idx", int'(bus.out_idx), k);
      if (bus.out_ready) k++;
      cyc++;
      tick();
    end
    check("st_accepts", k, N);
    check("st_idle", int'(bus.out_valid), 0);
    check("st_cnt", int'(frame_cnt), 2);
    bus.out_ready = 1'b1;

    // Back-to-back frames with in_valid held high
    bus.in_valid = 1'b1;
    bus.in_data  = FB;
    tick();
    bus.in_data = FC;
    for (int b = 0; b < 2*N; b++) begin
      check("bb_inrdy", int'(bus.in_ready), int'(b == N-1 || b == 2*N-1));
      check("bb_valid", int'(bus.out_valid), 1);
      check("bb_data", int'(bus.out_data),
            b < N ? el(FB, b) : el(FC, b-N));
      check("bb_idx", int'(bus.out_idx), b % N);
      if (b == 2*N-1) bus.in_valid = 1'b0;
      tick();
    end
    check("bb_idle", int'(bus.out_valid), 0);
    check("bb_cnt", int'(frame_cnt), 4);

    // Unsorted frame sets sticky order_err
    bus.in_valid = 1'b1;
    bus.in_data  = FU;
    tick();
    bus.in_valid = 1'b0;
    check("u_err0", int'(order_err), 0);
    tick();
    check("u_err_idx0", int'(order_err), 0);
    tick();
    check("u_err_idx1", int'(order_err), 1);
    for (int i = 0; i < N-2; i++) tick();
    check("u_cnt", int'(frame_cnt), 5);
    send(FA, 1'b1);
    check("u_sticky", int'(order_err), 1);
    check("u_cnt2", int'(frame_cnt), 6);

    // Reset mid-frame after beat idx2 accepted
    bus.in_valid = 1'b1;
    bus.in_data  = F16;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mr_idx3", int'(bus.out_idx), 3);
    rst_n = 1'b0;
    #1;
    check("mr_valid", int'(bus.out_valid), 0);
    check("mr_cnt", int'(frame_cnt), 0);
    check("mr_err", int'(order_err), 0);
    check("mr_idx", int'(bus.out_idx), 0);
    tick();
    rst_n = 1'b1;
    send(F16, 1'b1);
    check("mr_cnt1", int'(frame_cnt), 1);

    // Counter wrap from a clean reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int f = 0; f < 256; f++) send(FB, 1'b0);
    check("wrap0", int'(frame_cnt), 0);
    send(FB, 1'b1);
    check("wrap1", int'(frame_cnt), 1);
    check("wrap_err", int'(order_err), 0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
